tt_capture_engine: RTL and testbench

Exhaustive response reader for the synthesized single-output benchmark netlists. It drives every input vector of a combinational function under test (FUT) in ascending binary order. After a programmable settle time it samples the FUT output and stores the complete truth table for readback, together with a ones count and an optional MISR signature. It is the measurement end of the benchmark flow: netlists produce `y0` from `x0..x6`, and this block reads `y0` back for equivalence checking against the original PLA.

---
 rtl/tt_capture_engine.sv | 101 ++++++++++
 tb/tb_tt_capture_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_capture_engine.sv
// Exhaustive truth-table capture engine: sweeps every FUT input vector, samples y_in, stores table/ones count.
// Optional MISR signature over the sampled stream is enabled by defining TT_CAPTURE_MISR_EN.
module tt_capture_engine #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] x_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  input  logic [N_IN-1:0] tt_rd_addr,
  output logic            tt_rd_data,
  output logic [N_IN:0]   ones_count,
  output logic [15:0]     signature
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [N_IN-1:0] X_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [DEPTH-1:0] tt;

  // Table lives in flops so reset can clear it and reads stay zero-latency.
  assign tt_rd_data = tt[tt_rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      x_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
      tt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_out      <= '0;
            ones_count <= '0;
            cnt        <= SETTLE_CNT;
            busy       <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == 4'd1) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          tt[x_out]  <= y_in;
          ones_count <= ones_count + {{N_IN{1'b0}}, y_in};
          if (x_out == X_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            x_out <= x_out + 1'b1;
            cnt   <= SETTLE_CNT;
            state <= HOLD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TT_CAPTURE_MISR_EN
  logic [15:0] misr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misr <= 16'hFFFF;
    end else if (state == IDLE && start) begin
      misr <= 16'hFFFF;
    end else if (state == SAMPLE) begin
      misr <= {misr[14:0], 1'b0} ^ ((misr[15] ^ y_in) ? 16'h1021 : 16'h0000);
    end
  end

  assign signature = misr;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_tt_capture_engine.sv
// Directed bench for tt_capture_engine: table-driven sweeps over several FUTs plus
// start-held, reset-mid-sweep and reseed sequences.
module tb_tt_capture_engine;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [6:0]  x_a, x_b;
  logic        y_a, y_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [6:0]  rd_addr;
  logic        rd_a, rd_b;
  logic [7:0]  ones_a, ones_b;
  logic [15:0] sig_a, sig_b;
  logic [2:0]  dly;
  int          fut_a;
  int          n_cmp;
  int          n_bad;

`ifdef TT_CAPTURE_MISR_EN
  localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
  localparam logic [15:0] SIG_RST = 16'h0000;
`endif

  tt_capture_engine #(.N_IN(7), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x_out(x_a), .y_in(y_a),
    .busy(busy_a), .done(done_a), .tt_rd_addr(rd_addr), .tt_rd_data(rd_a),
    .ones_count(ones_a), .signature(sig_a)
  );

  tt_capture_engine #(.N_IN(7), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .x_out(x_b), .y_in(y_b),
    .busy(busy_b), .done(done_b), .tt_rd_addr(rd_addr), .tt_rd_data(rd_b),
    .ones_count(ones_b), .signature(sig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic fut_val(input int f, input int a);
    case (f)
      0:       return a[0];
      1:       return (a == 127);
      3:       return a[6];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    y_a = fut_val(fut_a, int'(x_a));
  end

  // Slow FUT: x[6] through three flops, so it needs SETTLE=3 to read correctly.
  always @(posedge clk) begin
    dly <= {dly[1:0], x_b[6]};
  end
  assign y_b = dly[2];

  function automatic logic [127:0] exp_table(input int f);
    logic [127:0] t;
    for (int a = 0; a < 128; a++) t[a] = fut_val(f, a);
    return t;
  endfunction

  function automatic logic [15:0] misr_model(input int f);
    logic [15:0] s;
    logic        fb;
    s = SIG_RST;
`ifdef TT_CAPTURE_MISR_EN
    for (int a = 0; a < 128; a++) begin
      fb = s[15] ^ fut_val(f, a);
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
`endif
    return s;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  task automatic check_vec(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic read_table(input int sel, output logic [127:0] t);
    for (int a = 0; a < 128; a++) begin
      rd_addr = 7'(a);
      #1;
      t[a] = (sel != 0) ? rd_b : rd_a;
    end
  endtask

  // Pulses start for one cycle; lat counts edges from acceptance until done is seen.
  task automatic run_sweep(input int sel, output int lat, output logic busy0);
    @(negedge clk);
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    busy0 = (sel != 0) ? busy_b : busy_a;
    lat = 0;
    while (!((sel != 0) ? done_b : done_a) && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    int sel;
    int fut;
    int ones;
    int lat;
  } vec_t;

  vec_t         vecs[5];
  logic [15:0]  sigs[5];
  logic [127:0] tbl;
  int           lat;
  logic         busy0;
  int           k;
  int           done_cnt;
  int           done1_k;
  int           done2_k;
  int           low_cnt;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    rd_addr = '0;
    fut_a   = 0;

    vecs[0] = '{sel: 0, fut: 0, ones: 64, lat: 256};
    vecs[1] = '{sel: 0, fut: 1, ones: 1,  lat: 256};
    vecs[2] = '{sel: 0, fut: 2, ones: 0,  lat: 256};
    vecs[3] = '{sel: 0, fut: 1, ones: 1,  lat: 256};
    vecs[4] = '{sel: 1, fut: 3, ones: 64, lat: 512};

    // Reset state
    #12;
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_x", int'(x_a), 0);
    check("rst_ones", int'(ones_a), 0);
    check("rst_sig", int'(sig_a), int'(SIG_RST));
    read_table(0, tbl);
    check_vec("rst_table", tbl, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      fut_a = vecs[i].fut;
      run_sweep(vecs[i].sel, lat, busy0);
      check($sformatf("v%0d_busy_start", i), int'(busy0), 1);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_done", i), int'((vecs[i].sel != 0) ? busy_b : busy_a), 0);
      @(negedge clk);
      check($sformatf("v%0d_ones", i), int'((vecs[i].sel != 0) ? ones_b : ones_a), vecs[i].ones);
      sigs[i] = (vecs[i].sel != 0) ? sig_b : sig_a;
      check($sformatf("v%0d_sig", i), int'(sigs[i]), int'(misr_model(vecs[i].fut)));
      read_table(vecs[i].sel, tbl);
      check_vec($sformatf("v%0d_table", i), tbl, exp_table(vecs[i].fut));
    end

    check("reseed_same_sig", int'(sigs[3]), int'(sigs[1]));
`ifdef TT_CAPTURE_MISR_EN
    check("and_vs_zero_sig_differ", int'(sigs[1] != sigs[2]), 1);
`endif

    // start held high: sweep, DONE, IDLE re-accepts start, second sweep
    fut_a    = 0;
    done_cnt = 0;
    done1_k  = -1;
    done2_k  = -1;
    low_cnt  = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (k = 0; k <= 700; k++) begin
      @(negedge clk);
      if (k == 299) start_a = 1'b0;
      if (done_a) begin
        done_cnt++;
        if (done1_k < 0) done1_k = k; else if (done2_k < 0) done2_k = k;
      end
      if (!busy_a && k < 514) low_cnt++;
    end
    check("held_done1", done1_k, 256);
    check("held_done2", done2_k, 514);
    check("held_done_count", done_cnt, 2);
    check("held_busy_low_gap", low_cnt, 2);

    // Reset mid-sweep
    fut_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_x", int'(x_a), 0);
    check("mid_rst_ones", int'(ones_a), 0);
    check("mid_rst_sig", int'(sig_a), int'(SIG_RST));
    read_table(0, tbl);
    check_vec("mid_rst_table", tbl, '0);
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    run_sweep(0, lat, busy0);
    check("post_rst_latency", lat, 256);
    @(negedge clk);
    check("post_rst_ones", int'(ones_a), 64);
    read_table(0, tbl);
    check_vec("post_rst_table", tbl, exp_table(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
